// File: rtl/elevator_pkg.sv
// Purpose: shared car-state encoding and constants for the car controller and direction FSM.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package elevator_pkg;

    localparam int NUM_FLOORS_DEFAULT = 6;

    // Ground floor in one-hot form; the car's home position after reset.
    localparam logic [NUM_FLOORS_DEFAULT-1:0] FLOOR0 = NUM_FLOORS_DEFAULT'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DOOR_OPEN = 2'd1,
        MOVING    = 2'd2
    } car_state_t;

    // Direction FSM gives Up/Down; an ambiguous pair (both low or both high)
    // carries no information, so the previous heading is kept.
    function automatic logic dir_sample(input logic up, input logic down, input logic prev);
        return (up ^ down) ? up : prev;
    endfunction

endpackage

// File: rtl/floor_timer.sv
// Purpose: loadable down-counter shared by floor-to-floor travel and door dwell.
// Latency: load takes effect on the next edge; done is decoded from the registered count.
// Backpressure: none; en low freezes the count, the count saturates at zero.
//
// Ports:
//   Clock, Reset      rising-edge clock, synchronous active-high reset (count -> 0)
//   load_val, load    reload value and strobe (load has priority over en)
//   en                decrement enable
//   done              count == 0
module floor_timer #(
    parameter int W = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [W-1:0] load_val,
    input  logic         load,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/elevator_car_controller.sv
// Purpose: executes Up/Down decisions: latches calls, moves the car one floor per interval, opens the door.
// Latency: call latched on the edge it is seen; departure one edge later; TRAVEL_CYCLES edges per floor.
// Backpressure: none; estop freezes travel and holds an open door open, calls keep latching meanwhile.
//
// Ports:
//   Clock, Reset   rising-edge clock, synchronous active-high reset
//   call           hall/car button levels, one bit per floor
//   estop          emergency stop level
//   Up, Down       heading from the direction FSM
//   currentFloor   one-hot car position (registered)
//   inputfloors    pending requests (registered)
//   door_open      door open (decoded from registered state)
//   moving         car travelling (decoded from registered state)
module elevator_car_controller
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = NUM_FLOORS_DEFAULT,
    parameter int TRAVEL_CYCLES = 50,
    parameter int DOOR_CYCLES   = 100
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NUM_FLOORS-1:0] call,
    input  logic                  estop,
    input  logic                  Up,
    input  logic                  Down,
    output logic [NUM_FLOORS-1:0] currentFloor,
    output logic [NUM_FLOORS-1:0] inputfloors,
    output logic                  door_open,
    output logic                  moving
);

    localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW   = $clog2(TMAX);

    // Timers are loaded with N-1 so that a phase lasts exactly N edges.
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
    localparam logic [NUM_FLOORS-1:0] FLOOR_GND = NUM_FLOORS'(FLOOR0);

    car_state_t            state, state_nx;
    logic [NUM_FLOORS-1:0] floor_nx;
    logic [NUM_FLOORS-1:0] clr;
    logic                  dir_up, dir_up_nx;
    logic                  tmr_load, tmr_en, tmr_done;
    logic [TW-1:0]         tmr_load_val;
    logic                  at_limit;

    floor_timer #(.W(TW)) u_timer (
        .Clock    (Clock),
        .Reset    (Reset),
        .load_val (tmr_load_val),
        .load     (tmr_load),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    // Shifting past the end floor would make currentFloor zero; treat it as "no move".
    assign at_limit = dir_up ? currentFloor[NUM_FLOORS-1] : currentFloor[0];

    always_comb begin
        state_nx     = state;
        floor_nx     = currentFloor;
        dir_up_nx    = dir_up;
        tmr_load     = 1'b0;
        tmr_load_val = TRAVEL_LOAD;
        tmr_en       = 1'b0;

        case (state)
            IDLE: begin
                if (!estop) begin
                    if ((inputfloors & currentFloor) != '0) begin
                        state_nx     = DOOR_OPEN;
                        tmr_load     = 1'b1;
                        tmr_load_val = DOOR_LOAD;
                    end else if (inputfloors != '0) begin
                        state_nx  = MOVING;
                        dir_up_nx = dir_sample(Up, Down, dir_up);
                        tmr_load  = 1'b1;
                    end
                end
            end

            MOVING: begin
                if (!estop) begin
                    if (!tmr_done) begin
                        tmr_en = 1'b1;
                    end else if (at_limit) begin
                        state_nx = IDLE;
                    end else begin
                        floor_nx = dir_up ? (currentFloor << 1) : (currentFloor >> 1);
                        // Decisions on arrival look at the floor being entered.
                        if ((inputfloors & floor_nx) != '0) begin
                            state_nx     = DOOR_OPEN;
                            tmr_load     = 1'b1;
                            tmr_load_val = DOOR_LOAD;
                        end else if (inputfloors != '0) begin
                            dir_up_nx = dir_sample(Up, Down, dir_up);
                            tmr_load  = 1'b1;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
            end

            DOOR_OPEN: begin
                // A press at this floor restarts the dwell and is absorbed by the clear below.
                if ((call & currentFloor) != '0) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = DOOR_LOAD;
                end else if (!tmr_done) begin
                    tmr_en = 1'b1;
                end else if (!estop) begin
                    state_nx = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // The floor being served is cleared for as long as the door is (or is about to be) open.
    assign clr = (state_nx == DOOR_OPEN) ? floor_nx : '0;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            currentFloor <= FLOOR_GND;
            inputfloors  <= '0;
            dir_up       <= 1'b1;
        end else begin
            state        <= state_nx;
            currentFloor <= floor_nx;
            inputfloors  <= (inputfloors | call) & ~clr;
            dir_up       <= dir_up_nx;
        end
    end

    assign door_open = (state == DOOR_OPEN);
    assign moving    = (state == MOVING);

endmodule
